// File: rtl/engine_csr_index_generator_core_if.sv
// Handshake bundle between the CSR-index configure FIFO, the index generator
// and the engine request FIFO.
interface engine_csr_index_generator_core_if #(
   parameter int INDEX_WIDTH = 32,
   parameter int ADDR_WIDTH  = 64,
   parameter int DEST_WIDTH  = 8
);
   logic                   cfg_valid;
   logic                   cfg_ready;
   logic [INDEX_WIDTH-1:0] cfg_index_start;
   logic [INDEX_WIDTH-1:0] cfg_index_end;
   logic [INDEX_WIDTH-1:0] cfg_array_size;
   logic [DEST_WIDTH-1:0]  cfg_destination;

   logic                   req_valid;
   logic                   req_ready;
   logic [INDEX_WIDTH-1:0] req_index;
   logic [ADDR_WIDTH-1:0]  req_address;
   logic [DEST_WIDTH-1:0]  req_destination;
   logic                   req_last;

   // master: configuration source and request sink; slave: the generator core
   modport master (
      output cfg_valid, cfg_index_start, cfg_index_end, cfg_array_size, cfg_destination,
      output req_ready,
      input  cfg_ready,
      input  req_valid, req_index, req_address, req_destination, req_last
   );

   modport slave (
      input  cfg_valid, cfg_index_start, cfg_index_end, cfg_array_size, cfg_destination,
      input  req_ready,
      output cfg_ready,
      output req_valid, req_index, req_address, req_destination, req_last
   );
endinterface

// File: rtl/engine_csr_index_generator_core.sv
// Pops CSR-index configurations and emits one memory read request per index,
// with ready/valid backpressure, pause gating and a completion counter.
module engine_csr_index_generator_core #(
   parameter int INDEX_WIDTH     = 32,
   parameter int ADDR_WIDTH      = 64,
   parameter int DEST_WIDTH      = 8,
   parameter int ELEM_BYTES_LOG2 = 2
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst_n,
   engine_csr_index_generator_core_if.slave bus,
   input  logic [ADDR_WIDTH-1:0] base_address,
   input  logic                  pause,
   output logic                  done_pulse,
   output logic                  cfg_error,
   output logic                  busy,
   output logic [31:0]           done_count
);
   // state | meaning
   // IDLE  | waiting for a configuration; cfg_ready mirrors cfg_valid
   // LOAD  | consistency check of the latched configuration
   // ISSUE | presenting requests until remaining reaches zero
   // DONE  | one-cycle completion, done_pulse high
   typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ISSUE, ST_DONE} state_t;

   state_t                 r_state;
   logic [INDEX_WIDTH-1:0] r_start;
   logic [INDEX_WIDTH-1:0] r_end;
   logic [INDEX_WIDTH-1:0] r_size;
   logic [DEST_WIDTH-1:0]  r_dest;
   logic [INDEX_WIDTH-1:0] r_idx;
   logic [INDEX_WIDTH-1:0] r_rem;
   logic                   r_req_valid;
   logic [INDEX_WIDTH-1:0] r_req_index;
   logic [ADDR_WIDTH-1:0]  r_req_address;
   logic [DEST_WIDTH-1:0]  r_req_dest;
   logic                   r_req_last;
   logic                   r_done_pulse;
   logic                   r_cfg_error;
   logic [31:0]            r_done_count;
   logic                   w_fire;
   logic [INDEX_WIDTH-1:0] w_idx_next;

   localparam logic [INDEX_WIDTH-1:0] ONE = INDEX_WIDTH'(1);
   localparam logic [INDEX_WIDTH-1:0] TWO = INDEX_WIDTH'(2);

   function automatic logic [ADDR_WIDTH-1:0] f_addr(input logic [INDEX_WIDTH-1:0] idx);
      return base_address + (ADDR_WIDTH'(idx) << ELEM_BYTES_LOG2);
   endfunction

   assign w_fire     = r_req_valid & bus.req_ready;
   assign w_idx_next = r_idx + ONE;

   always_ff @(posedge ap_clk or negedge ap_rst_n) begin
      if (!ap_rst_n) begin
         r_state       <= ST_IDLE;
         r_start       <= '0;
         r_end         <= '0;
         r_size        <= '0;
         r_dest        <= '0;
         r_idx         <= '0;
         r_rem         <= '0;
         r_req_valid   <= 1'b0;
         r_req_index   <= '0;
         r_req_address <= '0;
         r_req_dest    <= '0;
         r_req_last    <= 1'b0;
         r_done_pulse  <= 1'b0;
         r_cfg_error   <= 1'b0;
         r_done_count  <= '0;
      end else begin
         r_done_pulse <= 1'b0;
         r_cfg_error  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (bus.cfg_valid) begin
                  r_start <= bus.cfg_index_start;
                  r_end   <= bus.cfg_index_end;
                  r_size  <= bus.cfg_array_size;
                  r_dest  <= bus.cfg_destination;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               if (r_end != r_start + r_size) begin
                  r_cfg_error <= 1'b1;
                  r_state     <= ST_IDLE;
               end else if (r_size == '0) begin
                  r_done_pulse <= 1'b1;
                  r_done_count <= r_done_count + 32'd1;
                  r_state      <= ST_DONE;
               end else begin
                  r_idx      <= r_start;
                  r_rem      <= r_size;
                  r_req_dest <= r_dest;
                  r_state    <= ST_ISSUE;
                  // present the first request straight away to reach T+2 latency
                  if (!pause) begin
                     r_req_valid   <= 1'b1;
                     r_req_index   <= r_start;
                     r_req_address <= f_addr(r_start);
                     r_req_last    <= (r_size == ONE);
                  end
               end
            end
            ST_ISSUE: begin
               if (w_fire) begin
                  r_idx <= w_idx_next;
                  r_rem <= r_rem - ONE;
                  if (r_rem == ONE) begin
                     r_req_valid  <= 1'b0;
                     r_req_last   <= 1'b0;
                     r_done_pulse <= 1'b1;
                     r_done_count <= r_done_count + 32'd1;
                     r_state      <= ST_DONE;
                  end else if (!pause) begin
                     r_req_valid   <= 1'b1;
                     r_req_index   <= w_idx_next;
                     r_req_address <= f_addr(w_idx_next);
                     r_req_last    <= (r_rem == TWO);
                  end else begin
                     r_req_valid <= 1'b0;
                     r_req_last  <= 1'b0;
                  end
               end else if (!r_req_valid && r_rem != '0 && !pause) begin
                  r_req_valid   <= 1'b1;
                  r_req_index   <= r_idx;
                  r_req_address <= f_addr(r_idx);
                  r_req_last    <= (r_rem == ONE);
               end
            end
            ST_DONE: begin
               r_state <= ST_IDLE;
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.cfg_ready       = (r_state == ST_IDLE) & bus.cfg_valid;
   assign bus.req_valid       = r_req_valid;
   assign bus.req_index       = r_req_index;
   assign bus.req_address     = r_req_address;
   assign bus.req_destination = r_req_dest;
   assign bus.req_last        = r_req_last;
   assign done_pulse          = r_done_pulse;
   assign cfg_error           = r_cfg_error;
   assign busy                = (r_state != ST_IDLE);
   assign done_count          = r_done_count;
endmodule

// File: tb/tb_engine_csr_index_generator_core.sv
// Directed bench for engine_csr_index_generator_core: basic, backpressure,
// pause, index wrap, edge configurations and reset abort.
module tb_engine_csr_index_generator_core;
   localparam int IW = 32;
   localparam int AW = 64;
   localparam int DW = 8;

   logic          ap_clk = 1'b0;
   logic          ap_rst_n = 1'b0;
   logic [AW-1:0] base_address;
   logic          pause;
   logic          done_pulse;
   logic          cfg_error;
   logic          busy;
   logic [31:0]   done_count;

   engine_csr_index_generator_core_if #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .DEST_WIDTH(DW)) bus ();

   engine_csr_index_generator_core #(
      .INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .DEST_WIDTH(DW), .ELEM_BYTES_LOG2(2)
   ) dut (
      .ap_clk       (ap_clk),
      .ap_rst_n     (ap_rst_n),
      .bus          (bus.slave),
      .base_address (base_address),
      .pause        (pause),
      .done_pulse   (done_pulse),
      .cfg_error    (cfg_error),
      .busy         (busy),
      .done_count   (done_count)
   );

   always #5 ap_clk = ~ap_clk;

   int            checks = 0;
   int            failures = 0;
   logic [IW-1:0] exp_idx;
   logic [DW-1:0] exp_dest;
   int            exp_n;
   int            fires;
   int            pulses;
   logic [63:0]   basic_addr [4];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge ap_clk);
      @(negedge ap_clk);
   endtask

   // Accept cycle T and LOAD cycle T+1; returns at the negedge of T+2.
   task automatic push_cfg(input logic [IW-1:0] s, input logic [IW-1:0] e,
                           input logic [IW-1:0] n, input logic [DW-1:0] d);
      bus.cfg_valid       = 1'b1;
      bus.cfg_index_start = s;
      bus.cfg_index_end   = e;
      bus.cfg_array_size  = n;
      bus.cfg_destination = d;
      #1;
      chk("cfg_ready_accept", bus.cfg_ready, 1);
      tick();
      bus.cfg_valid       = 1'b0;
      bus.cfg_index_start = '0;
      bus.cfg_index_end   = '0;
      bus.cfg_array_size  = '0;
      #1;
      chk("load_busy", busy, 1);
      chk("load_cfg_ready", bus.cfg_ready, 0);
      chk("load_req_valid", bus.req_valid, 0);
      exp_idx  = s;
      exp_dest = d;
      exp_n    = int'(n);
      fires    = 0;
      pulses   = 0;
      tick();
   endtask

   // Checks any presented request against the reference index sequence.
   task automatic step();
      #1;
      if (bus.req_valid) begin
         chk("req_index", bus.req_index, exp_idx);
         chk("req_address", bus.req_address, base_address + ({32'd0, exp_idx} << 2));
         chk("req_dest", bus.req_destination, exp_dest);
         chk("req_last", bus.req_last, (fires == exp_n - 1));
         if (bus.req_ready) begin
            exp_idx = exp_idx + 1'b1;
            fires++;
         end
      end
      if (done_pulse) pulses++;
      tick();
   endtask

   task automatic finish_cfg();
      int budget = 0;
      while (pulses == 0 && budget < 60) begin
         step();
         budget++;
      end
      chk("done_pulse_seen", pulses, 1);
   endtask

   initial begin
      basic_addr[0] = 64'h1028;
      basic_addr[1] = 64'h102C;
      basic_addr[2] = 64'h1030;
      basic_addr[3] = 64'h1034;
      bus.cfg_valid       = 1'b0;
      bus.cfg_index_start = '0;
      bus.cfg_index_end   = '0;
      bus.cfg_array_size  = '0;
      bus.cfg_destination = '0;
      bus.req_ready       = 1'b1;
      base_address        = 64'h1000;
      pause               = 1'b0;
      repeat (3) @(negedge ap_clk);
      #1;
      chk("rst_req_valid", bus.req_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_count", done_count, 0);
      chk("rst_req_address", bus.req_address, 0);
      @(negedge ap_clk);
      ap_rst_n = 1'b1;
      tick();

      // basic
      push_cfg(32'd10, 32'd14, 32'd4, 8'd3);
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("basic_valid", bus.req_valid, 1);
         chk("basic_index", bus.req_index, 10 + i);
         chk("basic_addr", bus.req_address, basic_addr[i]);
         chk("basic_last", bus.req_last, (i == 3));
         chk("basic_dest", bus.req_destination, 3);
         tick();
      end
      #1;
      chk("basic_done_pulse", done_pulse, 1);
      chk("basic_valid_off", bus.req_valid, 0);
      chk("basic_count", done_count, 1);
      tick();
      #1;
      chk("basic_pulse_once", done_pulse, 0);
      chk("basic_idle", busy, 0);

      // backpressure on index 11
      push_cfg(32'd10, 32'd14, 32'd4, 8'd3);
      step();
      bus.req_ready = 1'b0;
      repeat (3) begin
         #1;
         chk("bp_hold_valid", bus.req_valid, 1);
         chk("bp_hold_index", bus.req_index, 11);
         chk("bp_hold_addr", bus.req_address, 64'h102C);
         step();
      end
      bus.req_ready = 1'b1;
      finish_cfg();
      chk("bp_fires", fires, 4);
      chk("bp_count", done_count, 2);

      // pause after index 10 fires
      push_cfg(32'd10, 32'd14, 32'd4, 8'd3);
      step();
      pause = 1'b1;
      bus.req_ready = 1'b0;
      repeat (2) begin
         #1;
         chk("pause_keep_valid", bus.req_valid, 1);
         chk("pause_keep_index", bus.req_index, 11);
         step();
      end
      bus.req_ready = 1'b1;
      step();
      repeat (2) begin
         #1;
         chk("pause_blocked", bus.req_valid, 0);
         step();
      end
      pause = 1'b0;
      #1;
      chk("pause_release_lat", bus.req_valid, 0);
      step();
      finish_cfg();
      chk("pause_fires", fires, 4);
      chk("pause_count", done_count, 3);

      // index wrap
      push_cfg(32'hFFFF_FFFE, 32'h0000_0001, 32'd3, 8'hA5);
      #1;
      chk("wrap_first_addr", bus.req_address, 64'h4_0000_0FF8);
      finish_cfg();
      chk("wrap_fires", fires, 3);
      chk("wrap_end_index", exp_idx, 1);
      chk("wrap_count", done_count, 4);

      // size zero
      push_cfg(32'd7, 32'd7, 32'd0, 8'd1);
      #1;
      chk("zero_valid", bus.req_valid, 0);
      chk("zero_done_pulse", done_pulse, 1);
      chk("zero_count", done_count, 5);
      tick();
      #1;
      chk("zero_pulse_once", done_pulse, 0);
      chk("zero_idle", busy, 0);

      // malformed configuration
      push_cfg(32'd5, 32'd9, 32'd3, 8'd2);
      #1;
      chk("err_strobe", cfg_error, 1);
      chk("err_valid", bus.req_valid, 0);
      chk("err_idle", busy, 0);
      chk("err_no_pulse", done_pulse, 0);
      tick();
      #1;
      chk("err_strobe_once", cfg_error, 0);
      chk("err_count", done_count, 5);
      chk("err_valid_later", bus.req_valid, 0);

      // reset abort after two fires
      push_cfg(32'd20, 32'd28, 32'd8, 8'd4);
      step();
      step();
      #2;
      ap_rst_n = 1'b0;
      #1;
      chk("abort_req_valid", bus.req_valid, 0);
      chk("abort_req_last", bus.req_last, 0);
      chk("abort_req_index", bus.req_index, 0);
      chk("abort_req_address", bus.req_address, 0);
      chk("abort_req_dest", bus.req_destination, 0);
      chk("abort_busy", busy, 0);
      chk("abort_done_pulse", done_pulse, 0);
      chk("abort_cfg_error", cfg_error, 0);
      chk("abort_cfg_ready", bus.cfg_ready, 0);
      chk("abort_done_count", done_count, 0);
      tick();
      tick();
      ap_rst_n = 1'b1;
      tick();
      #1;
      chk("post_rst_count", done_count, 0);
      chk("post_rst_idle", busy, 0);
      push_cfg(32'd100, 32'd102, 32'd2, 8'd9);
      finish_cfg();
      chk("post_rst_fires", fires, 2);
      chk("post_rst_count_done", done_count, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
